// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
//
// Purpose:
//   This block drives a 1-to-4 demultiplexer. It registers the incoming data bit.
//   It steps the channel select through the channels, holding each one for DWELL
//   RUN cycles. A two-state FSM (IDLE/RUN) follows the run enable.
//   When the FSM leaves RUN, the select and dwell position are frozen.
//   They resume from the same point when the FSM re-enters RUN.
//   Reset is the only thing that returns the sequence to channel 00.
//
// Parameters:
//   DWELL   - number of RUN cycles each select value is held (1..256)
//
// Optional build macro:
//   CH_MASK_EN - adds the ch_mask input. Disabled channels are skipped when the
//                select advances. An all-zero mask stops the sequence.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   run enable, sampled on clk
//   inp      in   data bit to route
//   ch_mask  in   [3:0] channel enables, bit n = channel n (CH_MASK_EN only)
//   data     out  registered copy of inp, goes to the demux data input
//   select   out  [1:0] registered channel select, goes to the demux sel input
//   valid    out  high while data/select are live (FSM in RUN)
//   wrap     out  one-cycle pulse when select wraps back to a lower channel
module demux_sel_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inp,
`ifdef CH_MASK_EN
    input  logic [3:0] ch_mask,
`endif
    output logic       data,
    output logic [1:0] select,
    output logic       valid,
    output logic       wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             data_q, data_d;
    logic             wrap_q, wrap_d;

    logic [3:0]       mask;
    logic             any_ch;
    logic             run_ok;
    logic [1:0]       next_sel;

`ifdef CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = 4'b1111;
`endif

    assign any_ch = |mask;
    assign run_ok = en & any_ch;

    // Next enabled channel in ascending circular order starting after the
    // current one. Scanning k from far to near lets the nearest hit win. If no
    // other channel is enabled, the select stays on the current channel.
    always_comb begin
        next_sel = sel_q;
        for (int k = 3; k >= 1; k--) begin
            if (mask[sel_q + 2'(k)]) begin
                next_sel = sel_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        wrap_d  = 1'b0;

        // Every RUN cycle is counted, including the one in which en drops.
        // An advance still needs en high at the terminal count. So a channel
        // that reaches its last dwell cycle just as en falls advances on the
        // first RUN edge after resume.
        if (state_q == RUN && any_ch) begin
            if (cnt_q == CNT_LAST) begin
                if (en) begin
                    cnt_d  = '0;
                    sel_d  = next_sel;
                    wrap_d = (next_sel <= sel_q);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        state_d = run_ok ? RUN : IDLE;

        // Capture only when the next cycle is a RUN cycle, so data holds in IDLE.
        if (run_ok) begin
            data_d = inp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            data_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data   = data_q;
    assign select = sel_q;
    assign wrap   = wrap_q;
    // With an all-zero mask the outputs are not live, even in the cycle the
    // mask clears.
    assign valid  = (state_q == RUN) & any_ch;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
module tb_demux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       inp;
    logic [3:0] mask_r;

    logic [1:0] d_sel   [3];
    logic       d_data  [3];
    logic       d_valid [3];
    logic       d_wrap  [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_sel_sequencer #(.DWELL(4)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .inp(inp),
`ifdef CH_MASK_EN
        .ch_mask(mask_r),
`endif
        .data(d_data[0]), .select(d_sel[0]), .valid(d_valid[0]), .wrap(d_wrap[0])
    );

    demux_sel_sequencer #(.DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .inp(inp),
`ifdef CH_MASK_EN
        .ch_mask(mask_r),
`endif
        .data(d_data[1]), .select(d_sel[1]), .valid(d_valid[1]), .wrap(d_wrap[1])
    );

    demux_sel_sequencer #(.DWELL(2)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .inp(inp),
`ifdef CH_MASK_EN
        .ch_mask(mask_r),
`endif
        .data(d_data[2]), .select(d_sel[2]), .valid(d_valid[2]), .wrap(d_wrap[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: channel index, dwell cycles spent, run flag, per instance.
    int dwell_tab [3] = '{4, 1, 2};
    int m_ch   [3];
    int m_cnt  [3];
    bit m_run  [3];
    bit m_data [3];
    bit m_wrap [3];

    function automatic int next_enabled(input int cur, input logic [3:0] m);
        logic [3:0] mm;
        mm = m;
        for (int k = 1; k <= 4; k++) begin
            if (mm[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_ch[i] = 0; m_cnt[i] = 0; m_run[i] = 0; m_data[i] = 0; m_wrap[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    m_ch[i] = 0; m_cnt[i] = 0; m_run[i] = 0; m_data[i] = 0; m_wrap[i] = 0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    int nc;
                    bit live;
                    live = (mask_r != 4'b0000);
                    m_wrap[i] = 0;
                    if (m_run[i] && live) begin
                        if (m_cnt[i] == dwell_tab[i] - 1) begin
                            if (en) begin
                                nc = next_enabled(m_ch[i], mask_r);
                                m_wrap[i] = (nc <= m_ch[i]);
                                m_ch[i] = nc;
                                m_cnt[i] = 0;
                            end
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                    if (en && live) m_data[i] = inp;
                    m_run[i] = en && live;
                end
            end
        end
    end

    // Compare process: every output of every instance, once per cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_sel[%0d]", i),   int'(d_sel[i]),   m_ch[i]);
            chk($sformatf("model_valid[%0d]", i), int'(d_valid[i]), int'(m_run[i] && (mask_r != 4'b0000)));
            chk($sformatf("model_data[%0d]", i),  int'(d_data[i]),  int'(m_data[i]));
            chk($sformatf("model_wrap[%0d]", i),  int'(d_wrap[i]),  int'(m_wrap[i]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

`ifdef CH_MASK_EN
    int mseq [7] = '{0, 0, 1, 1, 3, 3, 1};
`endif

    initial begin
        int held;
        rst = 1'b1; en = 1'b0; inp = 1'b0; mask_r = 4'b1111;
        cyc(); cyc();
        chk("rst_sel", int'(d_sel[0]), 0);
        chk("rst_valid", int'(d_valid[0]), 0);
        chk("rst_data", int'(d_data[0]), 0);
        chk("rst_wrap", int'(d_wrap[0]), 0);

        rst = 1'b0;
        cyc();
        chk("idle_valid", int'(d_valid[0]), 0);

        // 20 valid cycles with inp=1: DWELL=4 steps every 4, DWELL=1 every cycle.
        en = 1'b1; inp = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            chk("seq4_sel", int'(d_sel[0]), ((n - 1) / 4) % 4);
            chk("seq4_wrap", int'(d_wrap[0]), int'(n == 17));
            chk("seq4_valid", int'(d_valid[0]), 1);
            chk("seq1_sel", int'(d_sel[1]), (n - 1) % 4);
        end

        // Alternating inp: data follows with one cycle latency.
        for (int n = 0; n < 8; n++) begin
            inp = n[0];
            cyc();
            chk("alt_data", int'(d_data[1]), n % 2);
            chk("alt_sel", int'(d_sel[1]), (20 + n) % 4);
        end

        // Pause after 6 valid cycles, resume from the frozen position.
        rst = 1'b1; en = 1'b0; cyc();
        rst = 1'b0; cyc();
        en = 1'b1; inp = 1'b0;
        repeat (6) cyc();
        chk("pause_pre_sel", int'(d_sel[0]), 1);
        en = 1'b0;
        cyc();
        chk("pause_valid", int'(d_valid[0]), 0);
        chk("pause_sel", int'(d_sel[0]), 1);
        cyc(); cyc();
        chk("pause_sel_held", int'(d_sel[0]), 1);
        chk("pause_wrap", int'(d_wrap[0]), 0);
        en = 1'b1;
        cyc();
        chk("resume_valid", int'(d_valid[0]), 1);
        chk("resume_sel_a", int'(d_sel[0]), 1);
        cyc();
        chk("resume_sel_b", int'(d_sel[0]), 1);
        cyc();
        chk("resume_sel_c", int'(d_sel[0]), 2);

        // en falls on the terminal-count edge: the advance waits for resume.
        cyc(); cyc(); cyc();
        chk("tc_sel", int'(d_sel[0]), 2);
        en = 1'b0;
        cyc();
        chk("tc_idle_valid", int'(d_valid[0]), 0);
        chk("tc_idle_sel", int'(d_sel[0]), 2);
        en = 1'b1;
        cyc();
        chk("tc_resume_sel", int'(d_sel[0]), 2);
        cyc();
        chk("tc_advance_sel", int'(d_sel[0]), 3);

        // Asynchronous reset mid-cycle while select=10.
        rst = 1'b1; cyc();
        rst = 1'b0; en = 1'b1; inp = 1'b1;
        repeat (9) cyc();
        chk("arst_pre_sel", int'(d_sel[0]), 2);
        chk("arst_pre_data", int'(d_data[0]), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", int'(d_sel[0]), 0);
        chk("arst_valid", int'(d_valid[0]), 0);
        chk("arst_data", int'(d_data[0]), 0);
        chk("arst_wrap", int'(d_wrap[0]), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("arst_rel_valid", int'(d_valid[0]), 1);
        chk("arst_rel_sel", int'(d_sel[0]), 0);
        chk("arst_rel_wrap", int'(d_wrap[0]), 0);

        // Mixed traffic against the model.
        for (int n = 0; n < 300; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            inp = 1'($urandom);
            rst = ($urandom_range(0, 59) == 0);
`ifdef CH_MASK_EN
            if ($urandom_range(0, 19) == 0) mask_r = 4'($urandom);
`endif
            cyc();
        end
        rst = 1'b0;

`ifdef CH_MASK_EN
        // Mask 1010 with DWELL=2: 00,00 then 01,01,11,11,01 (wrap on the 01 re-entry).
        rst = 1'b1; en = 1'b0; mask_r = 4'b1010; cyc();
        rst = 1'b0; en = 1'b1;
        for (int n = 0; n < 7; n++) begin
            cyc();
            chk("mask_sel", int'(d_sel[2]), mseq[n]);
            chk("mask_wrap", int'(d_wrap[2]), int'(n == 6));
        end
        held = int'(d_sel[2]);
        mask_r = 4'b0000;
        #1;
        chk("mask0_valid_now", int'(d_valid[2]), 0);
        cyc();
        chk("mask0_valid", int'(d_valid[2]), 0);
        chk("mask0_sel", int'(d_sel[2]), 1);
        cyc();
        chk("mask0_sel_held", int'(d_sel[2]), held);
        mask_r = 4'b1111;
        cyc(); cyc();
`else
        held = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
